// File: rtl/ritc_idelay_eye_scan.sv
// rtl/ritc_idelay_eye_scan.sv - per-bit IDELAY eye-scan sequencer
//
// Sweeps the delay tap of one (channel, bit) from 0 to 31. Each tap is
// written, allowed to settle, then sampled for pattern-checker errors. The
// longest contiguous run of good taps is located, and its centre is written
// back as the final delay.
//
// Ports:
//   user_clk_i    sole clock
//   user_rst_n_i  asynchronous active-low reset
//   start_i       1-cycle scan start (ignored while busy_o)
//   abort_i       1-cycle scan abandon (wins over start_i)
//   ch_i, bit_i   target channel / bit, latched on start_i
//   err_i         checker error strobe, one per errored cycle
//   dly_wr_o      1-cycle delay-write strobe
//   dly_dat_o     {ch, bit, tap}, valid with dly_wr_o
//   sample_o      high during each sample window
//   busy_o        scan in progress
//   done_o        1-cycle completion pulse (not on abort)
//   fail_o        last completed scan found no good tap
//   eye_start_o   first tap of the best run
//   eye_len_o     length of the best run (0..32)
//   center_o      tap applied at completion
module ritc_idelay_eye_scan #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          SAMPLE_CYCLES = 256,
  parameter logic [15:0] ERR_THRESH    = 16'd0,
  parameter logic [4:0]  DEFAULT_TAP   = 5'd0
) (
  input  logic        user_clk_i,
  input  logic        user_rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [2:0]  ch_i,
  input  logic [3:0]  bit_i,
  input  logic        err_i,
  output logic        dly_wr_o,
  output logic [11:0] dly_dat_o,
  output logic        sample_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [4:0]  eye_start_o,
  output logic [5:0]  eye_len_o,
  output logic [4:0]  center_o
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_APPLY,
    S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  ch_q;
  logic [3:0]  bit_q;
  logic [4:0]  tap;
  logic [15:0] cnt;
  logic [15:0] errcnt;
  logic [5:0]  run_len;
  logic [4:0]  run_start;
  logic [5:0]  best_len;
  logic [4:0]  best_start;

  // Evaluation of the just-sampled tap, used only in S_EVAL.
  logic       good;
  logic       close_run;
  logic [5:0] cand_len;
  logic [4:0] cand_start;
  logic [5:0] best_len_n;
  logic [4:0] best_start_n;
  logic [5:0] run_len_n;
  logic [4:0] run_start_n;

  // Centre of a run, rounded down; best_start + len/2 never exceeds 31.
  function automatic logic [4:0] calc_center(input logic [5:0] len,
                                             input logic [4:0] st);
    logic [5:0] sum;
    sum = {1'b0, st} + {1'b0, len[5:1]};
    if (len == 6'd0) begin
      return DEFAULT_TAP;
    end
    return sum[4:0];
  endfunction

  always_comb begin
    good         = (errcnt <= ERR_THRESH);
    close_run    = !good || (tap == 5'd31);
    // The run as it stands after this tap: extended if good, unchanged if bad.
    cand_len     = good ? (run_len + 6'd1) : run_len;
    cand_start   = (good && (run_len == 6'd0)) ? tap : run_start;
    best_len_n   = best_len;
    best_start_n = best_start;
    // Strictly longer only, so ties keep the lowest-start run.
    if (close_run && (cand_len > best_len)) begin
      best_len_n   = cand_len;
      best_start_n = cand_start;
    end
    run_len_n   = close_run ? 6'd0 : cand_len;
    run_start_n = cand_start;
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state       <= S_IDLE;
      ch_q        <= 3'd0;
      bit_q       <= 4'd0;
      tap         <= 5'd0;
      cnt         <= 16'd0;
      errcnt      <= 16'd0;
      run_len     <= 6'd0;
      run_start   <= 5'd0;
      best_len    <= 6'd0;
      best_start  <= 5'd0;
      dly_wr_o    <= 1'b0;
      dly_dat_o   <= 12'd0;
      sample_o    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      eye_start_o <= 5'd0;
      eye_len_o   <= 6'd0;
      center_o    <= 5'd0;
    end else if (abort_i && (state != S_IDLE)) begin
      // Leave the delay at the last tap written and keep reported results.
      state    <= S_IDLE;
      dly_wr_o <= 1'b0;
      sample_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state      <= S_LOAD;
            ch_q       <= ch_i;
            bit_q      <= bit_i;
            tap        <= 5'd0;
            cnt        <= 16'd0;
            errcnt     <= 16'd0;
            run_len    <= 6'd0;
            run_start  <= 5'd0;
            best_len   <= 6'd0;
            best_start <= 5'd0;
            fail_o     <= 1'b0;
            busy_o     <= 1'b1;
            // Outputs are registered, so the LOAD strobe is set on entry.
            dly_wr_o   <= 1'b1;
            dly_dat_o  <= {ch_i, bit_i, 5'd0};
          end
        end

        S_LOAD: begin
          dly_wr_o <= 1'b0;
          cnt      <= 16'd0;
          state    <= S_SETTLE;
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt      <= 16'd0;
            sample_o <= 1'b1;
            state    <= S_SAMPLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_SAMPLE: begin
          if (err_i && (errcnt != 16'hFFFF)) begin
            errcnt <= errcnt + 16'd1;
          end
          if (cnt == SAMPLE_LAST) begin
            cnt      <= 16'd0;
            sample_o <= 1'b0;
            state    <= S_EVAL;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_EVAL: begin
          run_len    <= run_len_n;
          run_start  <= run_start_n;
          best_len   <= best_len_n;
          best_start <= best_start_n;
          dly_wr_o   <= 1'b1;
          if (tap == 5'd31) begin
            // The APPLY strobe must carry the centre of the post-update best run.
            dly_dat_o <= {ch_q, bit_q, calc_center(best_len_n, best_start_n)};
            state     <= S_APPLY;
          end else begin
            tap       <= tap + 5'd1;
            errcnt    <= 16'd0;
            dly_dat_o <= {ch_q, bit_q, tap + 5'd1};
            state     <= S_LOAD;
          end
        end

        S_APPLY: begin
          dly_wr_o    <= 1'b0;
          eye_start_o <= best_start;
          eye_len_o   <= best_len;
          center_o    <= calc_center(best_len, best_start);
          fail_o      <= (best_len == 6'd0);
          done_o      <= 1'b1;
          state       <= S_DONE;
        end

        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          dly_wr_o <= 1'b0;
          sample_o <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ritc_idelay_eye_scan.sv
// tb/tb_ritc_idelay_eye_scan.sv - directed self-checking bench for ritc_idelay_eye_scan
module tb_ritc_idelay_eye_scan;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  ch;
  logic [3:0]  bsel;
  logic        err;
  logic        dly_wr;
  logic [11:0] dly_dat;
  logic        sample;
  logic        busy;
  logic        done;
  logic        fail;
  logic [4:0]  eye_start;
  logic [5:0]  eye_len;
  logic [4:0]  center;

  ritc_idelay_eye_scan #(
    .SETTLE_CYCLES(4),
    .SAMPLE_CYCLES(8),
    .ERR_THRESH(16'd0),
    .DEFAULT_TAP(5'd7)
  ) dut (
    .user_clk_i  (clk),
    .user_rst_n_i(rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .ch_i        (ch),
    .bit_i       (bsel),
    .err_i       (err),
    .dly_wr_o    (dly_wr),
    .dly_dat_o   (dly_dat),
    .sample_o    (sample),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .eye_start_o (eye_start),
    .eye_len_o   (eye_len),
    .center_o    (center)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Error mask per tap: bit t set means tap t produces errors every cycle.
  logic [31:0] err_mask = 32'd0;
  logic [4:0]  cur_tap  = 5'd0;
  logic [11:0] last_dat = 12'd0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [4:0]  wr_taps [0:1023];

  always @(negedge clk) begin
    if (dly_wr) begin
      cur_tap = dly_dat[4:0];
      last_dat = dly_dat;
      if (wr_cnt < 1024) wr_taps[wr_cnt] = dly_dat[4:0];
      wr_cnt++;
    end
    if (done) done_cnt++;
    err = err_mask[cur_tap];
  end

  task automatic pulse_start(input logic [2:0] c, input logic [3:0] b);
    @(negedge clk);
    ch = c;
    bsel = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after pulse_start; returns the cycle index at which done_o is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  int base_wr;
  int base_done;
  int cyc;
  int lim;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ch    = 3'd0;
    bsel  = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {dly_wr, dly_dat, sample, busy, done, fail, eye_start, eye_len, center}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: eye at taps 10-19
    err_mask = 32'hFFF0_03FF;
    base_wr = wr_cnt; base_done = done_cnt;
    pulse_start(3'd3, 4'd7);
    check("t1_busy_rise", busy, 1'b1);
    wait_done(cyc);
    check("t1_latency", cyc, 450);
    check("t1_eye_start", eye_start, 10);
    check("t1_eye_len", eye_len, 10);
    check("t1_center", center, 15);
    check("t1_fail", fail, 0);
    check("t1_final_dat", last_dat, {3'd3, 4'd7, 5'd15});
    check("t1_done_cnt", done_cnt - base_done, 1);
    check("t1_wr_cnt", wr_cnt - base_wr, 33);
    check("t1_busy_fall", busy, 0);

    // 2: no errors at all
    err_mask = 32'd0;
    base_wr = wr_cnt;
    pulse_start(3'd0, 4'd15);
    wait_done(cyc);
    check("t2_eye_start", eye_start, 0);
    check("t2_eye_len", eye_len, 32);
    check("t2_center", center, 16);
    check("t2_wr_cnt", wr_cnt - base_wr, 33);
    check("t2_wr_first", wr_taps[base_wr], 0);
    check("t2_wr_tap17", wr_taps[base_wr + 17], 17);
    check("t2_wr_tap31", wr_taps[base_wr + 31], 31);
    check("t2_wr_apply", wr_taps[base_wr + 32], 16);
    check("t2_final_dat", last_dat, {3'd0, 4'd15, 5'd16});

    // 3: every tap bad -> default tap
    err_mask = 32'hFFFF_FFFF;
    pulse_start(3'd5, 4'd11);
    wait_done(cyc);
    check("t3_fail", fail, 1);
    check("t3_eye_len", eye_len, 0);
    check("t3_eye_start", eye_start, 0);
    check("t3_center", center, 7);
    check("t3_final_tap", last_dat[4:0], 7);

    // 4: three equal runs 2-5, 12-15, 28-31 -> lowest start wins
    err_mask = 32'h0FFF_0FC3;
    pulse_start(3'd1, 4'd2);
    check("t4_fail_cleared_on_start", fail, 0);
    wait_done(cyc);
    check("t4_eye_start", eye_start, 2);
    check("t4_eye_len", eye_len, 4);
    check("t4_center", center, 4);

    // 4b: run 2-4 shorter than run 28-31 ending at tap 31
    err_mask = 32'h0FFF_FFE3;
    pulse_start(3'd1, 4'd2);
    wait_done(cyc);
    check("t4b_eye_start", eye_start, 28);
    check("t4b_eye_len", eye_len, 4);
    check("t4b_center", center, 30);
    check("t4b_final_tap", last_dat[4:0], 30);

    // 5: abort during SAMPLE of tap 9
    err_mask = 32'hFFF0_03FF;
    base_done = done_cnt;
    pulse_start(3'd2, 4'd4);
    lim = 0;
    while (!(sample && cur_tap == 5'd9) && lim < 1000) begin
      @(negedge clk);
      lim++;
    end
    check("t5_reach_tap9", {31'd0, sample && cur_tap == 5'd9}, 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy_low", busy, 0);
    check("t5_sample_low", sample, 0);
    base_wr = wr_cnt;
    repeat (200) @(negedge clk);
    check("t5_no_wr", wr_cnt - base_wr, 0);
    check("t5_no_done", done_cnt - base_done, 0);
    check("t5_last_tap", last_dat[4:0], 9);
    check("t5_eye_kept", {eye_start, eye_len, center, fail}, {5'd28, 6'd4, 5'd30, 1'b0});

    // abort and start together while idle: nothing starts
    base_wr = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_start_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("idle_abort_start_no_wr", wr_cnt - base_wr, 0);

    // 6a: start mid-scan ignored
    err_mask = 32'hFFF0_03FF;
    base_wr = wr_cnt;
    pulse_start(3'd4, 4'd1);
    lim = 0;
    while (wr_cnt - base_wr < 4 && lim < 1000) begin
      @(negedge clk);
      lim++;
    end
    pulse_start(3'd6, 4'd13);
    wait_done(cyc);
    check("t6_wr_cnt", wr_cnt - base_wr, 33);
    check("t6_wr_tap4", wr_taps[base_wr + 4], 4);
    check("t6_final_dat", last_dat, {3'd4, 4'd1, 5'd15});
    check("t6_eye", {eye_start, eye_len, center}, {5'd10, 6'd10, 5'd15});

    // 6b: asynchronous reset mid-SETTLE
    pulse_start(3'd2, 4'd3);
    lim = 0;
    while (cur_tap != 5'd2 && lim < 1000) begin
      @(negedge clk);
      lim++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset",
          {dly_wr, dly_dat, sample, busy, done, fail, eye_start, eye_len, center}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base_wr = wr_cnt;
    err_mask = 32'd0;
    pulse_start(3'd2, 4'd3);
    wait_done(cyc);
    check("t6_restart_first_tap", wr_taps[base_wr], 0);
    check("t6_restart_latency", cyc, 450);
    check("t6_restart_center", center, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
